ssram_arbiter: RTL
==================

# ssram_arbiter

Shares the byte-laned synchronous SRAM behind the AHB-to-SSRAM bridge with a second, non-AHB requester port (port B: DMA or debug). The bridge's SRAM-side signals (port A) pass through with zero added latency and absolute priority, because the bridge cannot be stalled. Port B commands are buffered in a small FIFO and issued in SRAM idle cycles, with read data returned one cycle after issue. Sits between the bridge's SRAM outputs and the four 8-bit sync RAM instances.

## Interface
- AW, 12, byte-address width; the RAMs use addr[AW-1:2]
- QD_LOG2, 1, log2 of the port B command FIFO depth (default 2 entries)

- HCLK  in  1  clock
- HRESETn  in  1  reset; asynchronous assert, active-low
- a_addr  in  AW  port A byte address (from the bridge)
- a_enb  in  4  port A per-lane enables
- a_wb  in  4  port A per-lane write enables
- a_din  in  32  port A write data
- a_dout  out  32  port A read data; sram_dout passed straight through
- b_valid  in  1  port B command valid
- b_ready  out  1  port B FIFO not full
- b_addr  in  AW  port B byte address; bits [1:0] forwarded unchanged
- b_write  in  1  1 = write, 0 = read
- b_be  in  4  port B write byte enables; ignored for reads
- b_wdata  in  32  port B write data
- b_rvalid  out  1  port B read data valid
- b_rdata  out  32  port B read data; sram_dout, meaningful only when b_rvalid=1
- sram_addr  out  AW  to RAMs
- sram_enb  out  4  to RAMs
- sram_wb  out  4  to RAMs
- sram_din  out  32  to RAMs
- sram_dout  in  32  from RAMs; one-cycle read latency, write-first
- stat_max_wait  out  8  only with the stats feature; otherwise tied to 0

## Operation
- A is active when |a_enb. A active: the sram_* outputs equal the a_* inputs combinationally. No B issue that cycle.
- A idle and FIFO non-empty: issue the FIFO head and pop it.
  - B write: sram_enb=b_be, sram_wb=b_be.
  - B read: sram_enb=4'hF, sram_wb=0.
  - sram_addr=b_addr, sram_din=b_wdata.
- A idle and FIFO empty: all sram_* outputs are 0.
- FIFO push when b_valid & b_ready. b_ready = !full. There is no bypass: a command never issues in its push cycle.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- A B read issued in cycle N sets the b_rvalid register for cycle N+1. A B write issued in cycle N produces no response.
- A reads: the bridge samples sram_dout only after its own access. A B read in the following cycle cannot corrupt A data because A priority means the two never overlap.
- B commands issue strictly in FIFO order.

## Timing
- Reset values:
  - FIFO empty, so b_ready=1.
  - b_rvalid=0.
  - stat counters 0.
  - sram_* outputs 0 unless a_enb is nonzero.
- Minimum B latency: accept in cycle N, issue in N+1, b_rvalid in N+2.
- Each cycle of A activity delays the B head by one cycle. B can starve indefinitely under continuous A traffic; this is accepted by design.
- FIFO pointers are QD_LOG2+1 bits and wrap modulo 2^(QD_LOG2+1).
  - full = (MSBs differ) & (low bits equal).
  - empty = (pointers equal).
- Reset asserted mid-operation:
  - FIFO is flushed.
  - A pending b_rvalid is dropped.
  - Outputs return to reset values asynchronously.

## Configuration
- SSRAM_ARB_STATS_EN defined:
  - An 8-bit saturating wait counter increments each cycle the FIFO is non-empty and A is active.
  - The counter clears on each B issue.
  - stat_max_wait holds the largest counter value seen since reset, saturating at 8'hFF.
- SSRAM_ARB_STATS_EN undefined: no counters are built; stat_max_wait = 0.

## Test plan
- A-only write of 32'hCAFEBABE to 0x010, then A read of 0x010. sram_* mirror a_* in the same cycle, and a_dout = 32'hCAFEBABE one cycle after the read.
- A idle, B write of 32'h12345678 to 0x014 (b_be=4'hF) accepted in cycle N, then B read of 0x014. The write issues in N+1. b_rvalid=1 with b_rdata = 32'h12345678 two cycles after the read is accepted.
- B write with b_be=4'b0001 and wdata 8'h55 to 0x010, then B read of 0x010. Result is 32'hCAFEBA55.
- a_enb=4'hF held for 5 cycles while a B read is pending. The B read issues in the first cycle a_enb=0. With SSRAM_ARB_STATS_EN defined, stat_max_wait = 5.
- Hold A active and push 2 B commands. b_ready=0, and a third b_valid is not accepted until one command issues.
- Pulse HRESETn low while a B read is pending and one is in flight. b_rvalid never asserts, b_ready=1, and the FIFO is empty after release.

Source files
------------

// File: rtl/ssram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ssram_arbiter_if
// Purpose  : Bridge port A, DMA/debug port B and SRAM-side signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ssram_arbiter_if #(
  parameter int AW = 12
) ();
  logic [AW-1:0] a_addr;
  logic [3:0]    a_enb;
  logic [3:0]    a_wb;
  logic [31:0]   a_din;
  logic [31:0]   a_dout;

  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic          b_write;
  logic [3:0]    b_be;
  logic [31:0]   b_wdata;
  logic          b_rvalid;
  logic [31:0]   b_rdata;

  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_enb;
  logic [3:0]    sram_wb;
  logic [31:0]   sram_din;
  logic [31:0]   sram_dout;

  // Arbiter view
  modport slave (
    input  a_addr, a_enb, a_wb, a_din,
    output a_dout,
    input  b_valid, b_addr, b_write, b_be, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    output sram_addr, sram_enb, sram_wb, sram_din,
    input  sram_dout
  );

  // Requesters plus RAM view
  modport master (
    output a_addr, a_enb, a_wb, a_din,
    input  a_dout,
    output b_valid, b_addr, b_write, b_be, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    input  sram_addr, sram_enb, sram_wb, sram_din,
    output sram_dout
  );
endinterface
`default_nettype wire

// File: rtl/ssram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ssram_arbiter
// Purpose  : Shares the byte-laned SSRAM between the AHB bridge (port A,
//            absolute priority, zero latency) and a FIFO-buffered port B.
//            Optional wait statistics enabled by macro SSRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ssram_arbiter #(
  parameter int AW      = 12,
  parameter int QD_LOG2 = 1
) (
  input  wire logic        HCLK,
  input  wire logic        HRESETn,
  ssram_arbiter_if.slave   bus,
  output logic [7:0]       stat_max_wait
);

  localparam int               c_depth   = 1 << QD_LOG2;
  localparam logic [QD_LOG2:0] c_ptr_one = 1;

  logic [AW-1:0]    r_q_addr  [c_depth];
  logic             r_q_write [c_depth];
  logic [3:0]       r_q_be    [c_depth];
  logic [31:0]      r_q_wdata [c_depth];

  logic [QD_LOG2:0]   r_wr_ptr;
  logic [QD_LOG2:0]   r_rd_ptr;
  logic               r_rvalid;
  logic [QD_LOG2-1:0] w_wr_idx;
  logic [QD_LOG2-1:0] w_rd_idx;
  logic               w_a_active;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_wr_idx   = r_wr_ptr[QD_LOG2-1:0];
  assign w_rd_idx   = r_rd_ptr[QD_LOG2-1:0];
  assign w_a_active = |bus.a_enb;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[QD_LOG2] != r_rd_ptr[QD_LOG2]) &&
                      (w_wr_idx == w_rd_idx);
  // Pointers are registered, so a command pushed this cycle cannot issue yet
  assign w_push     = bus.b_valid && !w_full;
  assign w_pop      = !w_a_active && !w_empty;

  assign bus.b_ready  = !w_full;
  assign bus.b_rvalid = r_rvalid;
  assign bus.b_rdata  = bus.sram_dout;
  assign bus.a_dout   = bus.sram_dout;

  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_q_addr[w_wr_idx]  <= bus.b_addr;
      r_q_write[w_wr_idx] <= bus.b_write;
      r_q_be[w_wr_idx]    <= bus.b_be;
      r_q_wdata[w_wr_idx] <= bus.b_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_rvalid <= w_pop && !r_q_write[w_rd_idx];
    end
  end

  always_comb begin
    bus.sram_addr = '0;
    bus.sram_enb  = 4'h0;
    bus.sram_wb   = 4'h0;
    bus.sram_din  = 32'h0;
    if (w_a_active) begin
      bus.sram_addr = bus.a_addr;
      bus.sram_enb  = bus.a_enb;
      bus.sram_wb   = bus.a_wb;
      bus.sram_din  = bus.a_din;
    end else if (w_pop) begin
      bus.sram_addr = r_q_addr[w_rd_idx];
      bus.sram_enb  = r_q_write[w_rd_idx] ? r_q_be[w_rd_idx] : 4'hF;
      bus.sram_wb   = r_q_write[w_rd_idx] ? r_q_be[w_rd_idx] : 4'h0;
      bus.sram_din  = r_q_wdata[w_rd_idx];
    end
  end

`ifdef SSRAM_ARB_STATS_EN
  logic [7:0] r_wait_cnt;
  logic [7:0] r_max_wait;
  logic [7:0] w_wait_nxt;

  // Head waits only while A holds the RAM; any B issue restarts the count
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_pop) begin
      w_wait_nxt = 8'h00;
    end else if (w_a_active && !w_empty && (r_wait_cnt != 8'hFF)) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wait_cnt <= 8'h00;
      r_max_wait <= 8'h00;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      if (w_wait_nxt > r_max_wait) begin
        r_max_wait <= w_wait_nxt;
      end
    end
  end

  assign stat_max_wait = r_max_wait;
`else
  assign stat_max_wait = 8'h00;
`endif

endmodule
`default_nettype wire
